// File: rtl/pingpong_frame_buffer_if.sv
// Producer/consumer bundle for the ping-pong frame buffer.
// The master side is the producer plus consumer; the slave side is the buffer.
interface pingpong_frame_buffer_if #(
  parameter int DATA_W = 8
);
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;
  logic              wr_ready;
  logic              rd_en;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              underrun;
  logic              swap_pulse;
  logic              front_sel;

  modport master (
    output wr_valid, wr_data, wr_last, rd_en,
    input  wr_ready, rd_valid, rd_data, rd_last, underrun, swap_pulse, front_sel
  );

  modport slave (
    input  wr_valid, wr_data, wr_last, rd_en,
    output wr_ready, rd_valid, rd_data, rd_last, underrun, swap_pulse, front_sel
  );
endinterface

// File: rtl/pingpong_frame_buffer.sv
// Ping-pong frame buffer: the producer fills the back bank while the consumer
// drains the front bank. Banks swap once the back frame is committed (full or
// wr_last) and the front frame is fully read. Reads have one cycle of latency.
module pingpong_frame_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    flush,
  pingpong_frame_buffer_if.slave  bus
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    FILLING   = 1'b0,
    COMMITTED = 1'b1
  } back_state_e;

  back_state_e       state_q, state_d;
  logic              front_sel_q, front_sel_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  back_len_q, back_len_d;
  logic [CNT_W-1:0]  front_cnt_q, front_cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_last_q, rd_last_d;
  logic              underrun_q, underrun_d;
  logic              swap_pulse_q, swap_pulse_d;

  logic [DATA_W-1:0] mem_q [2][DEPTH];

  logic wr_acc;
  logic rd_acc;
  logic front_empty;
  logic do_swap;

  assign front_empty = (front_cnt_q == '0);
  assign wr_acc      = bus.wr_valid && (state_q == FILLING);
  assign rd_acc      = bus.rd_en && !front_empty;
  // The swap waits for a read-empty front, so it never lands on the last read.
  assign do_swap     = (state_q == COMMITTED) && front_empty;

  // Next-state for the back-side fill FSM, front counters and read outputs.
  always_comb begin
    state_d      = state_q;
    front_sel_d  = front_sel_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    back_len_d   = back_len_q;
    front_cnt_d  = front_cnt_q;
    rd_valid_d   = rd_acc;
    rd_data_d    = rd_data_q;
    rd_last_d    = 1'b0;
    underrun_d   = bus.rd_en && front_empty;
    swap_pulse_d = do_swap;

    if (wr_acc) begin
      if ((wr_ptr_q == LAST_ADDR) || bus.wr_last) begin
        // Pointer parks on the final word; it is rewound at the swap.
        state_d    = COMMITTED;
        back_len_d = {1'b0, wr_ptr_q} + 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end

    if (rd_acc) begin
      rd_data_d   = mem_q[front_sel_q][rd_ptr_q];
      rd_last_d   = (front_cnt_q == CNT_W'(1));
      front_cnt_d = front_cnt_q - 1'b1;
      if (front_cnt_q != CNT_W'(1)) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end

    if (do_swap) begin
      state_d     = FILLING;
      front_sel_d = ~front_sel_q;
      front_cnt_d = back_len_q;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
    end
  end

  // Control and output registers; flush clears everything except rd_data.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= FILLING;
      front_sel_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      back_len_q   <= '0;
      front_cnt_q  <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_last_q    <= 1'b0;
      underrun_q   <= 1'b0;
      swap_pulse_q <= 1'b0;
    end else if (flush) begin
      state_q      <= FILLING;
      front_sel_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      back_len_q   <= '0;
      front_cnt_q  <= '0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      underrun_q   <= 1'b0;
      swap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      front_sel_q  <= front_sel_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      back_len_q   <= back_len_d;
      front_cnt_q  <= front_cnt_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      rd_last_q    <= rd_last_d;
      underrun_q   <= underrun_d;
      swap_pulse_q <= swap_pulse_d;
    end
  end

  // Bank storage: accepted words go into the back bank; never cleared.
  always_ff @(posedge clk) begin
    if (resetn && !flush && wr_acc) begin
      mem_q[~front_sel_q][wr_ptr_q] <= bus.wr_data;
    end
  end

  assign bus.wr_ready   = (state_q == FILLING);
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_last    = rd_last_q;
  assign bus.underrun   = underrun_q;
  assign bus.swap_pulse = swap_pulse_q;
  assign bus.front_sel  = front_sel_q;

endmodule
